if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the DLX pipeline. It sits directly upstream of the decode stage and feeds it the fetched instruction word and PC_ID, which is the fetch address + 4. It owns the program counter and drives the instruction-memory request/acknowledge handshake. A 2-entry prefetch buffer absorbs decode stalls and memory wait states. It applies redirects from decode (jumps) and from execute (taken branches), and squashes wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, prefetch buffer entries (only 2 is supported)

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_req  out  1  instruction-memory request
- i_addr  out  32  fetch address, word aligned
- i_ack  in  1  memory accepted i_req this cycle; i_rdata valid in the same cycle
- i_rdata  in  32  instruction word from memory
- pc_cmd_ID  in  1  jump redirect from decode
- pc_in_ID  in  32  jump target
- pc_cmd_EX  in  1  branch redirect from execute
- pc_in_EX  in  32  branch target
- stall_ID  in  1  decode cannot accept an instruction this cycle
- valid_ID  out  1  i_data_read/PC_ID hold a real instruction
- i_data_read  out  32  instruction presented to decode; NOP_INSN when !valid_ID
- PC_ID  out  32  fetch address + 4 of the presented instruction; 0 when !valid_ID

## Operation
- **Registers:** fetch_pc; FIFO entries {instr, pc+4}; state in {FETCH, DRAIN}.
- **Presentation:** the FIFO head is presented to decode.
  - pop = valid_ID && !stall_ID.
- **Request rule:** i_req = reset_n && (state==DRAIN || count<2 || (count==2 && pop)).
  - i_addr = fetch_pc in FETCH.
  - In DRAIN, i_addr is the abandoned address.
  - Once raised, i_req and i_addr stay stable until i_ack.
- **Accept, no redirect:** on i_ack in FETCH, push {i_rdata, fetch_pc+4} and set fetch_pc += 4.
- **Address arithmetic:** modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- **Redirect priority:** pc_cmd_EX > pc_cmd_ID.
  - pc_cmd_ID is ignored while stall_ID=1.
- **Redirect effect:**
  - Flush the FIFO, including any same-cycle push.
  - fetch_pc <= target.
  - If i_req is high and i_ack is low, go to DRAIN and keep requesting the old address.
  - If i_ack is high in the redirect cycle, drop the returned word and stay in FETCH.
- **DRAIN:**
  - On i_ack: discard the data, go to FETCH.
  - Another redirect in DRAIN updates fetch_pc and stays in DRAIN.
- **Simultaneous push and pop** at count==2: count stays 2.

## Timing
- **Reset (reset_n=0 at an edge):**
  - fetch_pc=RESET_PC, FIFO empty, state=FETCH.
  - Outputs while reset_n=0: i_req=0, valid_ID=0, i_data_read=NOP_INSN, PC_ID=0.
- **Reset mid-operation:**
  - The outstanding request is abandoned.
  - Memory must tolerate i_req dropping during reset.
- **Latency:** i_ack in cycle n → valid_ID in cycle n+1. There is no bypass.
- **Throughput:** with zero-wait memory (i_ack with i_req), 1 instruction/cycle sustained.
- **Redirect in cycle n:**
  - valid_ID=0 in cycle n+1.
  - First target word presented in cycle n+2 at the earliest (zero-wait, no DRAIN).
- **Stall:** a stalled head stays stable indefinitely. With the FIFO full and no pop, i_req=0.

## Structure
- **dlx_pkg** (shared package):
  - XLEN=32
  - NOP_INSN=32'h0000_0000
  - typedef enum fetch_state_t {FETCH, DRAIN}
  - typedef struct fetch_entry_t {instr, pc4}
- **Sub-module fetch_fifo:** 2-entry FIFO of fetch_entry_t with push, pop, flush, count and head outputs.
  - Flush overrides push.

## Test plan
- Reset release, zero-wait memory, stall_ID=0 → addresses 0,4,8… one per cycle; valid_ID from cycle 1; PC_ID=4,8,12…
- stall_ID=1 for 5 cycles at steady state → FIFO fills to 2; i_req=0; head stable. Release → no instruction lost or duplicated.
- pc_cmd_EX with pc_in_EX=0x100 while a request to 0x20 waits 3 cycles for i_ack:
  - DRAIN holds i_addr=0x20; word 0x20 is discarded.
  - Next request is 0x100; PC_ID=0x104.
- pc_cmd_ID (target 0x40) and pc_cmd_EX (target 0x80) in the same cycle → next fetch 0x80; FIFO flushed.
- pc_cmd_ID with stall_ID=1 → ignored. Redirect to 32'hFFFF_FFFC → next fetch 0x0 after it; PC_ID of that word = 0x0.
- reset_n=0 during an outstanding request → i_req=0 next cycle. After release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types and constants.
// Used by the fetch stage, its prefetch FIFO and the memory interface.
package dlx_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
   } fetch_entry_t;

   // Sequential fetch address; wraps modulo 2^32
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
// The read data is valid in the same cycle as the acknowledge.
interface if_stage_if;
   import dlx_pkg::*;

   logic            i_req;
   logic [XLEN-1:0] i_addr;
   logic            i_ack;
   logic [XLEN-1:0] i_rdata;

   modport master (
      output i_req,
      output i_addr,
      input  i_ack,
      input  i_rdata
   );

   modport slave (
      input  i_req,
      input  i_addr,
      output i_ack,
      output i_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer of {instr, pc+4}; entry 0 is always the head.
// Flush wins over push; push and pop together at full keeps it full.
module fetch_fifo
   import dlx_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t entry_in,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_entry_t e0_q, e1_q;
   logic [1:0]   count_q;
   logic         do_pop;

   assign do_pop = pop && (count_q != 2'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= 2'd0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (count_q != FULL) begin
                  if (count_q == 2'd0) e0_q <= entry_in;
                  else                 e1_q <= entry_in;
                  count_q <= count_q + 2'd1;
               end
            end
            2'b01: begin
               e0_q    <= e1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind what remains
               if (count_q == 2'd1) begin
                  e0_q <= entry_in;
               end else begin
                  e0_q <= e1_q;
                  e1_q <= entry_in;
               end
            end
            default: ;
         endcase
      end
   end

   assign count = count_q;
   assign head  = e0_q;

endmodule

// File: rtl/if_stage.sv
// DLX instruction-fetch stage: owns the PC, drives the instruction-memory handshake,
// buffers up to two fetched words for decode and squashes wrong-path fetches on redirect.
module if_stage
   import dlx_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   if_stage_if.master      imem,
   input  logic            pc_cmd_ID,
   input  logic [XLEN-1:0] pc_in_ID,
   input  logic            pc_cmd_EX,
   input  logic [XLEN-1:0] pc_in_EX,
   input  logic            stall_ID,
   output logic            valid_ID,
   output logic [XLEN-1:0] i_data_read,
   output logic [XLEN-1:0] PC_ID
);

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   fetch_state_t    state_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] drain_addr_q;

   fetch_entry_t    head;
   fetch_entry_t    entry_in;
   logic [1:0]      count;
   logic            redirect;
   logic [XLEN-1:0] target;
   logic            pop;
   logic            push;
   logic            req;
   logic            accept;

   // A stalled decode cannot own its jump yet, so only execute may redirect then
   assign redirect = pc_cmd_EX || (pc_cmd_ID && !stall_ID);
   assign target   = pc_cmd_EX ? pc_in_EX : pc_in_ID;

   assign valid_ID = reset_n && (count != 2'd0);
   assign pop      = valid_ID && !stall_ID;

   assign req = reset_n && ((state_q == DRAIN) || (count < FULL) || ((count == FULL) && pop));
   assign accept = req && imem.i_ack;
   assign push   = (state_q == FETCH) && accept && !redirect;

   assign entry_in.instr = imem.i_rdata;
   assign entry_in.pc4   = pc_next(fetch_pc_q);

   assign imem.i_req  = req;
   assign imem.i_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;

   assign i_data_read = valid_ID ? head.instr : NOP_INSN;
   assign PC_ID       = valid_ID ? head.pc4 : '0;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .entry_in (entry_in),
      .pop      (pop),
      .flush    (redirect),
      .count    (count),
      .head     (head)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= '0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (redirect) begin
                  fetch_pc_q <= target;
                  // An unacknowledged request must be held until memory takes it
                  if (req && !imem.i_ack) begin
                     state_q      <= DRAIN;
                     drain_addr_q <= fetch_pc_q;
                  end
               end else if (accept) begin
                  fetch_pc_q <= pc_next(fetch_pc_q);
               end
            end
            DRAIN: begin
               if (redirect)   fetch_pc_q <= target;
               if (imem.i_ack) state_q    <= FETCH;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a combinational memory model answers requests,
// and each cycle's outputs are compared against hand-computed values.
module tb_if_stage;
   import dlx_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ack_en;
   logic        pc_cmd_ID;
   logic [31:0] pc_in_ID;
   logic        pc_cmd_EX;
   logic [31:0] pc_in_EX;
   logic        stall_ID;
   logic        valid_ID;
   logic [31:0] i_data_read;
   logic [31:0] PC_ID;

   int total = 0;
   int bad   = 0;

   if_stage_if mem ();

   always #5 clk = ~clk;

   // Memory word at address A is A ^ 32'hE000_0000
   always_comb begin
      mem.i_ack   = mem.i_req && ack_en;
      mem.i_rdata = mem.i_addr ^ 32'hE000_0000;
   end

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem        (mem),
      .pc_cmd_ID   (pc_cmd_ID),
      .pc_in_ID    (pc_in_ID),
      .pc_cmd_EX   (pc_cmd_EX),
      .pc_in_EX    (pc_in_EX),
      .stall_ID    (stall_ID),
      .valid_ID    (valid_ID),
      .i_data_read (i_data_read),
      .PC_ID       (PC_ID)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; ack_en = 1'b1; stall_ID = 1'b0;
      pc_cmd_ID = 1'b0; pc_in_ID = '0; pc_cmd_EX = 1'b0; pc_in_EX = '0;
      tick(); tick(); #1;
      chk("rst_req",   32'(mem.i_req), 32'd0);
      chk("rst_valid", 32'(valid_ID),  32'd0);
      chk("rst_data",  i_data_read,    32'h0000_0000);
      chk("rst_pc",    PC_ID,          32'h0000_0000);

      // Cycle 0: first request at RESET_PC
      tick(); reset_n = 1'b1; #1;
      chk("c0_req",   32'(mem.i_req), 32'd1);
      chk("c0_addr",  mem.i_addr,     32'h0000_0000);
      chk("c0_valid", 32'(valid_ID),  32'd0);
      tick(); #1;
      chk("c1_valid", 32'(valid_ID), 32'd1);
      chk("c1_data",  i_data_read,   32'hE000_0000);
      chk("c1_pc",    PC_ID,         32'h0000_0004);
      chk("c1_addr",  mem.i_addr,    32'h0000_0004);
      tick(); #1;
      chk("c2_pc",   PC_ID,      32'h0000_0008);
      chk("c2_addr", mem.i_addr, 32'h0000_0008);
      tick(); #1;
      chk("c3_data", i_data_read, 32'hE000_0008);
      chk("c3_pc",   PC_ID,       32'h0000_000C);

      // Stall cycles 4..8
      tick(); stall_ID = 1'b1; #1;
      chk("c4_req", 32'(mem.i_req), 32'd1);
      tick(); #1;
      tick(); #1;
      chk("c6_req",  32'(mem.i_req), 32'd0);
      chk("c6_pc",   PC_ID,          32'h0000_0010);
      chk("c6_data", i_data_read,    32'hE000_000C);
      tick(); #1;
      tick(); #1;
      chk("c8_pc",  PC_ID,          32'h0000_0010);
      chk("c8_req", 32'(mem.i_req), 32'd0);
      tick(); stall_ID = 1'b0; #1;
      chk("c9_pc",   PC_ID,          32'h0000_0010);
      chk("c9_req",  32'(mem.i_req), 32'd1);
      chk("c9_addr", mem.i_addr,     32'h0000_0014);
      tick(); #1;
      chk("c10_pc",   PC_ID,       32'h0000_0014);
      chk("c10_data", i_data_read, 32'hE000_0010);
      tick(); #1;
      chk("c11_pc", PC_ID, 32'h0000_0018);

      // Request to 0x20 waits for ack; branch redirect to 0x100 meanwhile
      tick(); ack_en = 1'b0; #1;
      chk("c12_pc",   PC_ID,      32'h0000_001C);
      chk("c12_addr", mem.i_addr, 32'h0000_0020);
      tick(); pc_cmd_EX = 1'b1; pc_in_EX = 32'h0000_0100; #1;
      chk("c13_pc",   PC_ID,      32'h0000_0020);
      chk("c13_addr", mem.i_addr, 32'h0000_0020);
      tick(); pc_cmd_EX = 1'b0; #1;
      chk("c14_valid", 32'(valid_ID),  32'd0);
      chk("c14_req",   32'(mem.i_req), 32'd1);
      chk("c14_addr",  mem.i_addr,     32'h0000_0020);
      tick(); ack_en = 1'b1; #1;
      chk("c15_addr",  mem.i_addr,    32'h0000_0020);
      chk("c15_valid", 32'(valid_ID), 32'd0);
      tick(); #1;
      chk("c16_addr",  mem.i_addr,    32'h0000_0100);
      chk("c16_valid", 32'(valid_ID), 32'd0);

      // Jump and branch together: branch wins
      tick();
      pc_cmd_ID = 1'b1; pc_in_ID = 32'h0000_0040;
      pc_cmd_EX = 1'b1; pc_in_EX = 32'h0000_0080;
      #1;
      chk("c17_pc",   PC_ID,       32'h0000_0104);
      chk("c17_data", i_data_read, 32'hE000_0100);
      tick(); pc_cmd_ID = 1'b0; pc_cmd_EX = 1'b0; #1;
      chk("c18_valid", 32'(valid_ID), 32'd0);
      chk("c18_addr",  mem.i_addr,    32'h0000_0080);

      // Jump while decode is stalled is ignored
      tick(); stall_ID = 1'b1; pc_cmd_ID = 1'b1; pc_in_ID = 32'h0000_0040; #1;
      chk("c19_pc",   PC_ID,      32'h0000_0084);
      chk("c19_addr", mem.i_addr, 32'h0000_0084);
      tick(); stall_ID = 1'b0; pc_cmd_ID = 1'b0; #1;
      chk("c20_valid", 32'(valid_ID), 32'd1);
      chk("c20_pc",    PC_ID,         32'h0000_0084);
      chk("c20_addr",  mem.i_addr,    32'h0000_0088);

      // Jump to the last word; fetch wraps to 0
      tick(); pc_cmd_ID = 1'b1; pc_in_ID = 32'hFFFF_FFFC; #1;
      chk("c21_pc", PC_ID, 32'h0000_0088);
      tick(); pc_cmd_ID = 1'b0; #1;
      chk("c22_valid", 32'(valid_ID), 32'd0);
      chk("c22_addr",  mem.i_addr,    32'hFFFF_FFFC);
      tick(); #1;
      chk("c23_pc",   PC_ID,       32'h0000_0000);
      chk("c23_data", i_data_read, 32'h1FFF_FFFC);
      chk("c23_addr", mem.i_addr,  32'h0000_0000);

      // Reset during an outstanding request to 0x4
      tick(); ack_en = 1'b0; #1;
      chk("c24_addr", mem.i_addr,     32'h0000_0004);
      chk("c24_req",  32'(mem.i_req), 32'd1);
      tick(); reset_n = 1'b0; #1;
      chk("c25_req",   32'(mem.i_req), 32'd0);
      chk("c25_valid", 32'(valid_ID),  32'd0);
      chk("c25_data",  i_data_read,    32'h0000_0000);
      tick(); #1;
      chk("c26_req", 32'(mem.i_req), 32'd0);
      chk("c26_pc",  PC_ID,          32'h0000_0000);
      tick(); reset_n = 1'b1; ack_en = 1'b1; #1;
      chk("c27_req",   32'(mem.i_req), 32'd1);
      chk("c27_addr",  mem.i_addr,     32'h0000_0000);
      chk("c27_valid", 32'(valid_ID),  32'd0);
      tick(); #1;
      chk("c28_pc",   PC_ID,       32'h0000_0004);
      chk("c28_data", i_data_read, 32'hE000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
